// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Holds the CPU in reset, zero-fills instruction memory, then
//               streams program words into it from address 0.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W:0]   C_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] C_ADDR_ONE  = ADDR_W'(1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              w_hs;
    logic              w_room;
    logic              r_s_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_cpu_rst;
    logic              r_busy;
    logic              r_done;
    logic              r_overflow;
    logic [ADDR_W:0]   r_word_count;

    assign w_hs   = (r_state == S_LOAD) && s_valid;
    assign w_room = (r_word_count < C_DEPTH_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLEAR;
            S_CLEAR: if (r_imem_addr == C_ADDR_LAST) w_next = S_LOAD;
            S_LOAD:  if (w_hs && s_last) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  if (start) w_next = S_CLEAR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
            r_s_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cpu_rst    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= '0;
                        r_imem_wdata <= FILL_WORD;
                        r_word_count <= '0;
                        r_overflow   <= 1'b0;
                    end else begin
                        r_imem_we <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_imem_addr == C_ADDR_LAST) begin
                        r_imem_we <= 1'b0;
                    end else begin
                        r_imem_addr <= r_imem_addr + C_ADDR_ONE;
                    end
                end
                S_LOAD: begin
                    // word_count doubles as the next write address, so gaps in s_valid never skip a slot
                    if (w_hs && w_room) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_word_count[ADDR_W-1:0];
                        r_imem_wdata <= s_data;
                        r_word_count <= r_word_count + C_CNT_ONE;
                    end else begin
                        r_imem_we <= 1'b0;
                        if (w_hs) r_overflow <= 1'b1;
                    end
                end
                default: r_imem_we <= 1'b0;
            endcase

            // Status flags decode the upcoming state so they line up with it
            r_s_ready <= (w_next == S_LOAD);
            r_busy    <= (w_next == S_CLEAR) || (w_next == S_LOAD) || (w_next == S_FLUSH);
            r_done    <= (w_next == S_DONE);
            r_cpu_rst <= (w_next != S_DONE);
        end
    end

    assign s_ready    = r_s_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed, table-driven bench for imem_loader at DEPTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int C_DEPTH  = 16;
    localparam int C_ADDR_W = 4;

    logic                clk;
    logic                rst;
    logic                start;
    logic                s_valid;
    logic                s_ready;
    logic [31:0]         s_data;
    logic                s_last;
    logic                imem_we;
    logic [C_ADDR_W-1:0] imem_addr;
    logic [31:0]         imem_wdata;
    logic                cpu_rst;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [C_ADDR_W:0]   word_count;

    int n_checks;
    int n_errors;

    typedef struct {
        logic        start;
        logic        valid;
        logic        last;
        logic [31:0] data;
        logic        exp_we;
        logic [3:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_ready;
        logic        exp_done;
        logic        exp_cpu_rst;
        logic        exp_ovf;
        logic [4:0]  exp_wc;
    } vec_t;

    vec_t r_tbl[$];

    imem_loader #(
        .DEPTH     (C_DEPTH),
        .ADDR_W    (C_ADDR_W),
        .FILL_WORD (32'h0000_0000)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic v, input logic l, input logic [31:0] d,
                                input logic we, input logic [3:0] a, input logic [31:0] wd,
                                input logic rdy, input logic dn, input logic cr,
                                input logic ov, input logic [4:0] wc);
        vec_t t;
        t.start = st; t.valid = v; t.last = l; t.data = d;
        t.exp_we = we; t.exp_addr = a; t.exp_wdata = wd;
        t.exp_ready = rdy; t.exp_done = dn; t.exp_cpu_rst = cr;
        t.exp_ovf = ov; t.exp_wc = wc;
        return t;
    endfunction

    task automatic run_tbl(input string tag);
        for (int i = 0; i < r_tbl.size(); i++) begin
            start   = r_tbl[i].start;
            s_valid = r_tbl[i].valid;
            s_last  = r_tbl[i].last;
            s_data  = r_tbl[i].data;
            step();
            chk($sformatf("%s[%0d] we", tag, i), {31'b0, imem_we}, {31'b0, r_tbl[i].exp_we});
            if (r_tbl[i].exp_we) begin
                chk($sformatf("%s[%0d] addr", tag, i), {28'b0, imem_addr}, {28'b0, r_tbl[i].exp_addr});
                chk($sformatf("%s[%0d] wdata", tag, i), imem_wdata, r_tbl[i].exp_wdata);
            end
            chk($sformatf("%s[%0d] ready", tag, i), {31'b0, s_ready}, {31'b0, r_tbl[i].exp_ready});
            chk($sformatf("%s[%0d] done", tag, i), {31'b0, done}, {31'b0, r_tbl[i].exp_done});
            chk($sformatf("%s[%0d] cpu_rst", tag, i), {31'b0, cpu_rst}, {31'b0, r_tbl[i].exp_cpu_rst});
            chk($sformatf("%s[%0d] ovf", tag, i), {31'b0, overflow}, {31'b0, r_tbl[i].exp_ovf});
            chk($sformatf("%s[%0d] wc", tag, i), {27'b0, word_count}, {27'b0, r_tbl[i].exp_wc});
        end
        start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'h0;
        r_tbl.delete();
    endtask

    // Pulse start and expect exactly DEPTH fill writes, then s_ready.
    task automatic do_clear(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " wc cleared"}, {27'b0, word_count}, 32'd0);
        chk({tag, " ovf cleared"}, {31'b0, overflow}, 32'd0);
        chk({tag, " cpu_rst"}, {31'b0, cpu_rst}, 32'd1);
        chk({tag, " done low"}, {31'b0, done}, 32'd0);
        for (int i = 0; i < C_DEPTH; i++) begin
            chk($sformatf("%s clr[%0d] we", tag, i), {31'b0, imem_we}, 32'd1);
            chk($sformatf("%s clr[%0d] addr", tag, i), {28'b0, imem_addr}, i);
            chk($sformatf("%s clr[%0d] wdata", tag, i), imem_wdata, 32'h0);
            chk($sformatf("%s clr[%0d] busy", tag, i), {31'b0, busy}, 32'd1);
            chk($sformatf("%s clr[%0d] ready", tag, i), {31'b0, s_ready}, 32'd0);
            step();
        end
        chk({tag, " post-clear we"}, {31'b0, imem_we}, 32'd0);
        chk({tag, " post-clear ready"}, {31'b0, s_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 32'h0;
        repeat (3) step();

        chk("reset cpu_rst", {31'b0, cpu_rst}, 32'd1);
        chk("reset we", {31'b0, imem_we}, 32'd0);
        chk("reset addr", {28'b0, imem_addr}, 32'd0);
        chk("reset ready", {31'b0, s_ready}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset wc", {27'b0, word_count}, 32'd0);
        rst = 1'b0;

        // s_valid in IDLE must not start anything
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("idle no write", {31'b0, imem_we}, 32'd0);
        chk("idle not busy", {31'b0, busy}, 32'd0);

        // Continuous three-word program
        do_clear("load");
        r_tbl.push_back(mk(0, 1, 0, 32'h00500093, 1, 4'd0, 32'h00500093, 1, 0, 1, 0, 5'd1));
        r_tbl.push_back(mk(0, 1, 0, 32'h00A00113, 1, 4'd1, 32'h00A00113, 1, 0, 1, 0, 5'd2));
        r_tbl.push_back(mk(0, 1, 1, 32'h002081B3, 1, 4'd2, 32'h002081B3, 0, 0, 1, 0, 5'd3));
        r_tbl.push_back(mk(0, 0, 0, 32'h0,        0, 4'd0, 32'h0,        0, 1, 0, 0, 5'd3));
        r_tbl.push_back(mk(0, 1, 0, 32'hFFFFFFFF, 0, 4'd0, 32'h0,        0, 1, 0, 0, 5'd3));
        run_tbl("load");

        // Gapped s_valid, with a start pulse in LOAD that must be ignored
        do_clear("bp");
        r_tbl.push_back(mk(0, 1, 0, 32'h11111111, 1, 4'd0, 32'h11111111, 1, 0, 1, 0, 5'd1));
        r_tbl.push_back(mk(1, 0, 0, 32'hDEADBEEF, 0, 4'd0, 32'h0,        1, 0, 1, 0, 5'd1));
        r_tbl.push_back(mk(0, 0, 0, 32'hDEADBEEF, 0, 4'd0, 32'h0,        1, 0, 1, 0, 5'd1));
        r_tbl.push_back(mk(0, 1, 0, 32'h22222222, 1, 4'd1, 32'h22222222, 1, 0, 1, 0, 5'd2));
        r_tbl.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 4'd0, 32'h0,        1, 0, 1, 0, 5'd2));
        r_tbl.push_back(mk(0, 1, 1, 32'h33333333, 1, 4'd2, 32'h33333333, 0, 0, 1, 0, 5'd3));
        r_tbl.push_back(mk(0, 0, 0, 32'h0,        0, 4'd0, 32'h0,        0, 1, 0, 0, 5'd3));
        run_tbl("bp");

        // 18 words into a 16-word memory
        do_clear("ovf");
        for (int i = 0; i < 18; i++) begin
            s_valid = 1'b1;
            s_last  = (i == 17);
            s_data  = 32'hA000_0000 + i;
            step();
            if (i < C_DEPTH) begin
                chk($sformatf("ovf w%0d we", i), {31'b0, imem_we}, 32'd1);
                chk($sformatf("ovf w%0d addr", i), {28'b0, imem_addr}, i);
                chk($sformatf("ovf w%0d wdata", i), imem_wdata, 32'hA000_0000 + i);
                chk($sformatf("ovf w%0d flag", i), {31'b0, overflow}, 32'd0);
                chk($sformatf("ovf w%0d wc", i), {27'b0, word_count}, i + 1);
            end else begin
                chk($sformatf("ovf w%0d dropped", i), {31'b0, imem_we}, 32'd0);
                chk($sformatf("ovf w%0d flag", i), {31'b0, overflow}, 32'd1);
                chk($sformatf("ovf w%0d wc", i), {27'b0, word_count}, 32'd16);
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        step();
        chk("ovf done", {31'b0, done}, 32'd1);
        chk("ovf cpu_rst", {31'b0, cpu_rst}, 32'd0);
        chk("ovf sticky", {31'b0, overflow}, 32'd1);
        chk("ovf wc held", {27'b0, word_count}, 32'd16);

        // Restart from DONE clears flags; then reset lands mid-LOAD
        do_clear("rerun");
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hB000_0000 + i;
            step();
            chk($sformatf("rerun w%0d addr", i), {28'b0, imem_addr}, i);
        end
        chk("rerun wc", {27'b0, word_count}, 32'd5);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst cpu_rst", {31'b0, cpu_rst}, 32'd1);
        chk("async rst we", {31'b0, imem_we}, 32'd0);
        chk("async rst ready", {31'b0, s_ready}, 32'd0);
        chk("async rst done", {31'b0, done}, 32'd0);
        chk("async rst wc", {27'b0, word_count}, 32'd0);
        #2;
        rst = 1'b0;
        s_valid = 1'b0;

        do_clear("one");
        r_tbl.push_back(mk(0, 1, 1, 32'h00000013, 1, 4'd0, 32'h00000013, 0, 0, 1, 0, 5'd1));
        r_tbl.push_back(mk(0, 0, 0, 32'h0,        0, 4'd0, 32'h0,        0, 1, 0, 0, 5'd1));
        run_tbl("one");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
